data_mem_arbiter: RTL
=====================

// Module: data_mem_arbiter
// PURPOSE
//  Shares the single 64-bit data memory (Memoria64) between two requesters: port 0 = CPU
//  multicycle control path, port 1 = debug/DMA loader. Serialises accesses, drives the memory
//  address/data/Wr pins and returns read data with a one-cycle response pulse.
//  Sits between the control FSM/datapath and memdata; one access in flight at a time.
// PARAMETERS
//  ADDR_W      64  address width of requests and memory pins
//  DATA_W      64  data width
//  MEM_LAT     1   cycles from address applied to valid Dataout (>=1)
// PORTS
//  clk          in   1       clock, all state updates on rising edge
//  reset        in   1       synchronous, active-high
//  req_valid    in   2       per-port request; held stable until req_ready seen
//  req_we       in   2       per-port 1=write, 0=read
//  req_addr0    in   ADDR_W  port 0 address
//  req_addr1    in   ADDR_W  port 1 address
//  req_wdata0   in   DATA_W  port 0 write data
//  req_wdata1   in   DATA_W  port 1 write data
//  req_ready    out  2       one-hot accept pulse, 1 cycle
//  rsp_valid    out  2       one-hot completion pulse, 1 cycle
//  rsp_rdata    out  DATA_W  read data, valid while rsp_valid!=0; 0 for write acks
//  mem_raddress out  ADDR_W  to Memoria64 raddress
//  mem_waddress out  ADDR_W  to Memoria64 waddress
//  mem_datain   out  DATA_W  to Memoria64 Datain
//  mem_wr       out  1       to Memoria64 Wr
//  mem_dataout  in   DATA_W  from Memoria64 Dataout
//  busy         out  1       high from accept until response cycle inclusive
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=1 (port 0 wins first tie), all outputs 0, latency counter 0.
//  FSM: IDLE -> READ_WAIT | WRITE -> RESP -> IDLE.
//  IDLE: if any req_valid, pick winner; pulse req_ready[w] this cycle; latch addr/wdata/we/w.
//   Tie (both valid): grant port != last_grant; update last_grant=w. Single valid: grant it.
//   Next state READ_WAIT (we=0) or WRITE (we=1). No valid: stay, outputs idle.
//  READ_WAIT: mem_raddress=latched addr; count MEM_LAT cycles; in last cycle capture
//   mem_dataout into rsp register; -> RESP.
//  WRITE: mem_waddress=mem_raddress=latched addr, mem_datain=latched wdata, mem_wr=1 exactly
//   this one cycle; -> RESP.
//  RESP: rsp_valid[w]=1, rsp_rdata=captured data (0 for write); -> IDLE. New request not
//   accepted in RESP; earliest next accept is the cycle after RESP.
//  Latency: read accept->rsp = MEM_LAT+1 cycles; write accept->rsp = 2 cycles.
//  mem_wr is 0 in every state except WRITE; memory address pins hold latched addr from
//   accept through RESP, 0 in IDLE.
//  Requester dropping req_valid before ready: legal, request simply not served.
//  Request changed after ready: ignored (latched values used).
//  Reset mid-operation: abort immediately, no rsp_valid, no mem_wr pulse, back to IDLE.
//  Same port back-to-back while other waits: round-robin guarantees other port next.
// STRUCTURE
//  Package data_mem_arb_pkg: state enum {IDLE, READ_WAIT, WRITE, RESP}; port index typedef
//   (1 bit); NUM_PORTS=2 constant.
//  Sub-module rr_arbiter2: inputs req[1:0], last_grant; outputs grant one-hot, winner idx.
//   Combinational; last_grant register lives in the parent FSM.
// TESTING
//  1 Reset, idle: no req -> all outputs 0, mem_wr never 1 over 20 cycles.
//  2 Port0 write addr=0x10 data=0xDEADBEEF -> req_ready=01 cycle 0, mem_wr=1 cycle 1 with
//    waddress=0x10, rsp_valid=01 cycle 2, rsp_rdata=0; then port0 read 0x10 -> rsp_rdata=0xDEADBEEF
//    MEM_LAT+1 cycles after ready.
//  3 Both ports read same cycle after reset -> port0 granted; both held -> port1 next, then port0;
//    strict alternation over 6 accesses.
//  4 Port1 read in flight, port0 raises write -> port0 ready only the cycle after port1 RESP;
//    no overlap of busy intervals.
//  5 Reset asserted during READ_WAIT and during WRITE -> no rsp_valid, mem_wr=0 next cycle,
//    state IDLE, port0 wins next tie.
//  6 MEM_LAT=3 build: read accept->rsp_valid exactly 4 cycles; address stable throughout.

Source files
------------

// File: rtl/data_mem_arb_pkg.sv
// rtl/data_mem_arb_pkg.sv - shared types and constants for the data memory arbiter
package data_mem_arb_pkg;

    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_WAIT = 2'd1,
        WRITE     = 2'd2,
        RESP      = 2'd3
    } state_t;

    typedef logic port_idx_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-port round-robin grant logic, purely combinational
module rr_arbiter2
    import data_mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_idx_t  last_grant,
    output logic [1:0] grant,
    output port_idx_t  winner
);

    // On a tie the port that did not win last time goes first; otherwise the lone requester wins
    always_comb begin
        winner = (req == 2'b11) ? ~last_grant : req[1];
        grant  = (req != 2'b00) ? (2'b01 << winner) : 2'b00;
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - serialises CPU and loader accesses onto the single data memory
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_we,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        req_ready,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_raddress,
    output logic [ADDR_W-1:0] mem_waddress,
    output logic [DATA_W-1:0] mem_datain,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_dataout,
    output logic              busy
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    state_t            state_q, state_d;
    port_idx_t         last_grant_q, last_grant_d;
    port_idx_t         port_q, port_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rsp_q, rsp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [1:0] grant;
    port_idx_t  winner;

    rr_arbiter2 u_rr (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .winner     (winner)
    );

    // Next-state and output decode; reset suppresses every pulse output in the same cycle
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rsp_d        = rsp_q;
        cnt_d        = cnt_q;
        req_ready    = 2'b00;
        rsp_valid    = 2'b00;
        rsp_rdata    = '0;
        mem_raddress = '0;
        mem_waddress = '0;
        mem_datain   = '0;
        mem_wr       = 1'b0;
        busy         = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req_valid != 2'b00) begin
                    req_ready    = grant;
                    busy         = 1'b1;
                    last_grant_d = winner;
                    port_d       = winner;
                    we_d         = req_we[winner];
                    addr_d       = winner ? req_addr1 : req_addr0;
                    wdata_d      = winner ? req_wdata1 : req_wdata0;
                    state_d      = req_we[winner] ? WRITE : READ_WAIT;
                end
            end
            READ_WAIT: begin
                busy         = 1'b1;
                mem_raddress = addr_q;
                mem_waddress = addr_q;
                if (cnt_q == CNT_LAST) begin
                    rsp_d   = mem_dataout;
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WRITE: begin
                busy         = 1'b1;
                mem_raddress = addr_q;
                mem_waddress = addr_q;
                mem_datain   = wdata_q;
                mem_wr       = 1'b1;
                rsp_d        = '0;
                state_d      = RESP;
            end
            RESP: begin
                busy         = 1'b1;
                mem_raddress = addr_q;
                mem_waddress = addr_q;
                rsp_valid    = 2'b01 << port_q;
                rsp_rdata    = rsp_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            req_ready = 2'b00;
            rsp_valid = 2'b00;
            mem_wr    = 1'b0;
        end
    end

    // State register with synchronous reset; last grant starts at port 1 so port 0 wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rsp_q        <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rsp_q        <= rsp_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule
